memory_access_controller: RTL and testbench
===========================================

Name: memory_access_controller

Overview:
- Parametrised load/store sequencer between the core's memory stage and a single-port, non-byte-enabled data memory of configurable width.
- Supports byte, halfword and word accesses with signed or unsigned loads.
- Splits misaligned accesses that span several memory words into sequential beats.
- Performs read-modify-write for partial-word stores, then returns a one-cycle response.

Parameters:
- ADDR_W, 12: byte-address width of req_addr.
- MEM_BYTES, 2: memory word width in bytes. Legal values are 1, 2 or 4; let LB = $clog2(MEM_BYTES).
- MEM_LATENCY, 1: cycles from a read issue to valid mem_rdata. Legal values are 1 or 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  access request.
- req_ready  out  1  controller idle; a request is accepted when req_valid and req_ready are both high.
- req_store  in  1  1 = store, 0 = load.
- req_type  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_signed  in  1  sign-extend the load result.
- req_addr  in  ADDR_W  byte address; any alignment allowed.
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_error  out  1  illegal req_type; qualified by rsp_valid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write strobe; only high together with mem_en.
- mem_addr  out  ADDR_W-LB  memory word address.
- mem_wdata  out  8*MEM_BYTES  write data.
- mem_rdata  in  8*MEM_BYTES  read data; valid MEM_LATENCY cycles after a read issue.
- busy  out  1  equals !req_ready.

Behaviour:
- Reset: synchronous, active-low. After the clk edge at which reset is sampled low:
  - state = IDLE, req_ready = 1, busy = 0.
  - rsp_valid = 0, rsp_error = 0, rsp_rdata = 0.
  - mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- All outputs are registered, except req_ready and busy, which are decoded from the state register.
- Request fields are captured at acceptance (cycle T). Inputs are don't-care afterwards.
- Access size and beats:
  - N = 1, 2 or 4 bytes.
  - First word W0 = req_addr >> LB; last word W1 = (req_addr + N - 1) >> LB, computed modulo 2^ADDR_W, so wrap-around past the top of memory is silent.
  - Beats = W1 - W0 + 1, computed modulo 2^(ADDR_W-LB).
- Byte order is little-endian: request byte k maps to address req_addr + k.
- States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- IDLE:
  - On accept with req_type == 11: go to RESP with rsp_error = 1 and no memory access.
  - Load, or store whose first beat is partial: go to RD_ISSUE.
  - Store whose first beat is fully covered: go to WR_ISSUE.
- RD_ISSUE: drive mem_en = 1, mem_we = 0 and the beat address for one cycle. Go to RD_WAIT.
- RD_WAIT:
  - Stays MEM_LATENCY cycles.
  - On the last cycle, capture the addressed mem_rdata bytes: into the load assembly register for a load, or into the merge buffer for a store.
  - Then go to the next beat (load), to WR_ISSUE (store), or to RESP.
- WR_ISSUE:
  - Drive mem_en = 1, mem_we = 1, with mem_wdata = merged word. Covered bytes come from req_wdata; uncovered bytes come from the read data, or are zero when the beat is fully covered.
  - Next beat, or RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle.
  - rsp_rdata = assembled bytes, zero- or sign-extended from bit 8N-1 per req_signed.
  - Next state IDLE. req_ready is low in RESP, so the earliest next accept is T' = rsp cycle + 1.
- Per-beat cost:
  - Load beat: 1 + MEM_LATENCY cycles.
  - Partial store beat: 2 + MEM_LATENCY cycles.
  - Full store beat: 1 cycle.
  - Response at the cycle following the last beat. Illegal request: response at T+1.
- Stores issue each beat's write before the next beat's read; beats are strictly sequential and never pipelined.
- Reset mid-operation aborts immediately:
  - No rsp_valid is produced.
  - Memory words already written stay written; a partial multi-beat store is acceptable.
- req_valid while busy is ignored; no queueing.

Decomposition:
- Package memory_access_pkg:
  - req_type encodings (TYPE_BYTE, TYPE_HALF, TYPE_WORD, TYPE_ILLEGAL).
  - State enum.
  - Function access_bytes(type).
  - Function beat_count(addr, type, LB).
- Sub-module memory_byte_align (combinational):
  - Given beat index, req_addr low bits and MEM_BYTES, produce per-lane byte selects and the covered mask.
  - Implement store-lane insertion / merge and load-lane extraction.
  - Implement final sign/zero extension.
- The FSM, beat counter, wait counter and assembly/merge registers live in memory_access_controller.

Test Plan:
All scenarios use MEM_BYTES = 2, MEM_LATENCY = 1, ADDR_W = 12.
1. Signed byte load, addr 0x003, word1 = 0x8012:
   - One read at mem_addr 1 in T+1.
   - rsp_valid at T+3 with rsp_rdata = 0xFFFFFF80.
   - Same load unsigned gives 0x00000080.
2. Misaligned word load, addr 0x001, words 0..2 = 0x2211, 0x4433, 0x6655:
   - Reads at mem_addr 0, 1, 2 in T+1, T+3, T+5.
   - rsp at T+7 with rsp_rdata = 0x55443322.
3. Byte store, addr 0x004, wdata 0x000000AB, word2 = 0x1234:
   - Read at T+1.
   - Write of 0x12AB to mem_addr 2 at T+3.
   - rsp_valid at T+4 with rsp_rdata = 0.
4. Aligned word store, addr 0x008, wdata 0xDEADBEEF:
   - No reads.
   - Writes 0xBEEF to mem_addr 4 at T+1 and 0xDEAD to mem_addr 5 at T+2.
   - rsp at T+3.
5. req_type = 11 store:
   - mem_en never asserted.
   - rsp_valid = 1 and rsp_error = 1 at T+1.
   - req_ready = 1 at T+2.
6. Halfword load at addr 0xFFF wraps:
   - Reads mem_addr 0x7FF, then 0x000.
   - Pull reset low during the second RD_WAIT: next cycle mem_en = 0, req_ready = 1, and no rsp_valid ever appears.

Source files
------------

// File: rtl/memory_access_controller_pkg.sv
// Shared types and helpers for the load/store sequencer: request encodings,
// FSM states and access-geometry functions.
package memory_access_pkg;

  typedef enum logic [1:0] {
    TYPE_BYTE    = 2'b00,
    TYPE_HALF    = 2'b01,
    TYPE_WORD    = 2'b10,
    TYPE_ILLEGAL = 2'b11
  } req_type_e;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    RESP
  } state_e;

  function automatic logic [2:0] access_bytes(input req_type_e t);
    case (t)
      TYPE_BYTE: return 3'd1;
      TYPE_HALF: return 3'd2;
      TYPE_WORD: return 3'd4;
      default:   return 3'd1;
    endcase
  endfunction

  // Beats depend only on the offset inside the first word, so address
  // wrap-around at the top of memory does not change the count.
  function automatic logic [2:0] beat_count(input logic [1:0] addr_lo, input req_type_e t,
                                            input int lb);
    int off;
    off = int'(addr_lo) & ((1 << lb) - 1);
    return 3'(((off + int'(access_bytes(t)) - 1) >> lb) + 1);
  endfunction

endpackage

// File: rtl/memory_access_controller_if.sv
// Core-request, response and data-memory signals of the load/store sequencer.
// slave = controller side, master = core plus memory side.
interface memory_access_controller_if #(
  parameter int ADDR_W    = 12,
  parameter int MEM_BYTES = 2
);
  localparam int LB = $clog2(MEM_BYTES);

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_store;
  logic [1:0]               req_type;
  logic                     req_signed;
  logic [ADDR_W-1:0]        req_addr;
  logic [31:0]              req_wdata;
  logic                     rsp_valid;
  logic [31:0]              rsp_rdata;
  logic                     rsp_error;
  logic                     mem_en;
  logic                     mem_we;
  logic [ADDR_W-LB-1:0]     mem_addr;
  logic [8*MEM_BYTES-1:0]   mem_wdata;
  logic [8*MEM_BYTES-1:0]   mem_rdata;
  logic                     busy;

  modport slave (
    input  req_valid, req_store, req_type, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error, mem_en, mem_we, mem_addr, mem_wdata,
           busy
  );

  modport master (
    output req_valid, req_store, req_type, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error, mem_en, mem_we, mem_addr, mem_wdata,
           busy
  );

endinterface

// File: rtl/memory_access_controller_byte_align.sv
// Lane steering for one memory beat: which lanes the request covers, store
// merge, load byte extraction and final sign/zero extension.
module memory_byte_align #(
  parameter int MEM_BYTES = 2
) (
  input  logic [2:0]             beat_i,
  input  logic [1:0]             off_i,
  input  logic [2:0]             nbytes_i,
  input  logic                   signed_i,
  input  logic [31:0]            wdata_i,
  input  logic [8*MEM_BYTES-1:0] base_i,
  input  logic [8*MEM_BYTES-1:0] rdata_i,
  input  logic [31:0]            asm_i,
  output logic [MEM_BYTES-1:0]   covered_o,
  output logic [8*MEM_BYTES-1:0] merged_o,
  output logic [31:0]            asm_o,
  output logic [31:0]            ext_o
);

  always_comb begin
    int k;
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    k         = 0;
    covered_o = '0;
    merged_o  = base_i;
    asm_o     = asm_i;
    for (int l = 0; l < MEM_BYTES; l++) begin
      // k is the request byte index that lands on lane l in this beat.
      k = int'(beat_i) * MEM_BYTES + l - int'(off_i);
      if (k >= 0 && k < int'(nbytes_i)) begin
        covered_o[l]        = 1'b1;
        merged_o[8*l +: 8]  = wdata_i[8*k +: 8];
        asm_o[8*k +: 8]     = rdata_i[8*l +: 8];
      end
    end
  end

  always_comb begin
    case (nbytes_i)
      3'd1:    ext_o = {{24{signed_i & asm_o[7]}}, asm_o[7:0]};
      3'd2:    ext_o = {{16{signed_i & asm_o[15]}}, asm_o[15:0]};
      default: ext_o = asm_o;
    endcase
  end

endmodule

// File: rtl/memory_access_controller.sv
// Load/store sequencer: splits byte/half/word accesses into memory-word beats,
// does read-modify-write for partial stores and returns a one-cycle response.
module memory_access_controller
  import memory_access_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int MEM_BYTES   = 2,
  parameter int MEM_LATENCY = 1
) (
  input logic                  clk,
  input logic                  reset,
  memory_access_controller_if.slave bus
);

  localparam int         LB       = $clog2(MEM_BYTES);
  localparam int         WA       = ADDR_W - LB;
  localparam int         MW       = 8 * MEM_BYTES;
  localparam logic [1:0] OFF_MASK = 2'(MEM_BYTES - 1);

  state_e            state_q, state_d;
  logic [2:0]        beat_q, beat_d;
  logic [1:0]        wait_q, wait_d;
  logic [31:0]       asm_q, asm_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_error_q, rsp_error_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [WA-1:0]     mem_addr_q, mem_addr_d;
  logic [MW-1:0]     mem_wdata_q, mem_wdata_d;

  logic              store_q;
  req_type_e         type_q;
  logic              signed_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic [2:0]        beats_q;

  logic [2:0]        al_beat;
  logic [1:0]        al_off;
  logic [2:0]        al_n;
  logic [31:0]       al_wdata;
  logic [MW-1:0]     al_base;
  logic [MEM_BYTES-1:0] covered;
  logic [MW-1:0]     merged;
  logic [31:0]       asm_ins;
  logic [31:0]       ext_rdata;
  logic              full_beat;
  logic              last_beat;
  logic              accept;

  assign accept    = (state_q == IDLE) && bus.req_valid;
  assign last_beat = (beat_q == beats_q - 3'd1);
  assign full_beat = &covered;

  // The aligner looks at the beat about to be written: beat 0 of the incoming
  // request in IDLE, the following beat in WR_ISSUE, the current one otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      al_beat  = 3'd0;
      al_off   = bus.req_addr[1:0] & OFF_MASK;
      al_n     = access_bytes(req_type_e'(bus.req_type));
      al_wdata = bus.req_wdata;
    end else begin
      al_beat  = (state_q == WR_ISSUE) ? beat_q + 3'd1 : beat_q;
      al_off   = off_q;
      al_n     = access_bytes(type_q);
      al_wdata = wdata_q;
    end
    al_base = (state_q == RD_WAIT) ? bus.mem_rdata : '0;
  end

  memory_byte_align #(.MEM_BYTES(MEM_BYTES)) u_align (
    .beat_i    (al_beat),
    .off_i     (al_off),
    .nbytes_i  (al_n),
    .signed_i  (signed_q),
    .wdata_i   (al_wdata),
    .base_i    (al_base),
    .rdata_i   (bus.mem_rdata),
    .asm_i     (asm_q),
    .covered_o (covered),
    .merged_o  (merged),
    .asm_o     (asm_ins),
    .ext_o     (ext_rdata)
  );

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    asm_d       = asm_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_type_e'(bus.req_type) == TYPE_ILLEGAL) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            beat_d     = 3'd0;
            asm_d      = '0;
            mem_en_d   = 1'b1;
            mem_addr_d = bus.req_addr[ADDR_W-1:LB];
            if (bus.req_store && full_beat) begin
              state_d     = WR_ISSUE;
              mem_we_d    = 1'b1;
              mem_wdata_d = merged;
            end else begin
              state_d = RD_ISSUE;
            end
          end
        end
      end
      RD_ISSUE: begin
        state_d = RD_WAIT;
        wait_d  = 2'd0;
      end
      RD_WAIT: begin
        if (wait_q == 2'(MEM_LATENCY - 1)) begin
          if (store_q) begin
            // mem_wdata doubles as the merge buffer for the read-modify-write.
            state_d     = WR_ISSUE;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = merged;
          end else begin
            asm_d = asm_ins;
            if (last_beat) begin
              state_d     = RESP;
              rsp_valid_d = 1'b1;
              rsp_rdata_d = ext_rdata;
            end else begin
              state_d    = RD_ISSUE;
              beat_d     = beat_q + 3'd1;
              mem_en_d   = 1'b1;
              mem_addr_d = mem_addr_q + 1'b1;
            end
          end
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      WR_ISSUE: begin
        if (last_beat) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          beat_d     = beat_q + 3'd1;
          mem_en_d   = 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
          if (full_beat) begin
            state_d     = WR_ISSUE;
            mem_we_d    = 1'b1;
            mem_wdata_d = merged;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      wait_q      <= '0;
      asm_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      asm_q       <= asm_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // NOTE: captured request fields carry no reset; they are always rewritten
  // at acceptance before anything reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      store_q  <= bus.req_store;
      type_q   <= req_type_e'(bus.req_type);
      signed_q <= bus.req_signed;
      off_q    <= bus.req_addr[1:0] & OFF_MASK;
      wdata_q  <= bus.req_wdata;
      beats_q  <= beat_count(bus.req_addr[1:0], req_type_e'(bus.req_type), LB);
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_memory_access_controller.sv
// Scoreboard bench for memory_access_controller: directed requests push
// expected memory operations and responses; monitors pop and compare.
module tb_memory_access_controller;
  import memory_access_pkg::*;

  localparam int ADDR_W      = 12;
  localparam int MEM_BYTES   = 2;
  localparam int MEM_LATENCY = 1;

  typedef struct {
    logic [31:0] rdata;
    logic        error;
    int          cyc;
  } rsp_exp_t;

  typedef struct {
    logic        we;
    logic [10:0] addr;
    logic [15:0] wdata;
    int          cyc;
  } mem_exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  memory_access_controller_if #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) bus ();

  memory_access_controller #(
    .ADDR_W     (ADDR_W),
    .MEM_BYTES  (MEM_BYTES),
    .MEM_LATENCY(MEM_LATENCY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  rsp_exp_t    rsp_q[$];
  mem_exp_t    mem_q[$];
  rsp_exp_t    rsp_e;
  mem_exp_t    mem_e;
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  int          t_acc      = 0;
  logic [15:0] mem [2048];
  logic [15:0] rdata_q;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memory with one cycle of read latency.
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[0]      = 16'h2211;
    mem[1]      = 16'h8012;
    mem[2]      = 16'h6655;
    mem[3]      = 16'h56F8;
    mem[6]      = 16'h9988;
    mem[11'h7FF] = 16'h3300;
    rdata_q     = 16'h0000;
    forever begin
      @(posedge clk);
      if (bus.mem_en === 1'b1) begin
        if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
        else                     rdata_q <= mem[bus.mem_addr];
      end
    end
  end
  assign bus.mem_rdata = rdata_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1 && bus.mem_en !== 1'b1) begin
      compared++;
      mismatched++;
      $display("FAIL mem_we_without_en: got mem_we=1 mem_en=%b expected mem_en=1", bus.mem_en);
    end
    if (bus.mem_en === 1'b1) begin
      if (mem_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_mem_op: got we=%b addr 0x%0h at cycle %0d expected no access",
                 bus.mem_we, bus.mem_addr, cyc);
      end else begin
        mem_e = mem_q.pop_front();
        check("mem_we", 32'(bus.mem_we), 32'(mem_e.we));
        check("mem_addr", 32'(bus.mem_addr), 32'(mem_e.addr));
        if (mem_e.we) check("mem_wdata", 32'(bus.mem_wdata), 32'(mem_e.wdata));
        check("mem_cycle", cyc, mem_e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_rsp: got rsp_valid with rdata 0x%0h at cycle %0d expected none",
                 bus.rsp_rdata, cyc);
      end else begin
        rsp_e = rsp_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, rsp_e.rdata);
        check("rsp_error", 32'(bus.rsp_error), 32'(rsp_e.error));
        check("rsp_cycle", cyc, rsp_e.cyc);
      end
    end
  end

  task automatic begin_req();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", 32'(bus.req_ready), 32'd1);
    t_acc = cyc;
  endtask

  task automatic exp_mem(input logic we, input logic [10:0] addr, input logic [15:0] wdata,
                         input int rel);
    mem_exp_t e;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    e.cyc   = t_acc + rel;
    mem_q.push_back(e);
  endtask

  task automatic fire(input logic store, input logic [1:0] rtype, input logic sgn,
                      input logic [11:0] addr, input logic [31:0] wdata, input bit has_rsp,
                      input logic [31:0] exp_rdata, input logic exp_err, input int rsp_lat);
    rsp_exp_t e;
    bus.req_store  = store;
    bus.req_type   = rtype;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
    if (has_rsp) begin
      e.rdata = exp_rdata;
      e.error = exp_err;
      e.cyc   = t_acc + rsp_lat;
      rsp_q.push_back(e);
    end
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'($urandom);
    bus.req_type   = 2'($urandom);
    bus.req_signed = 1'($urandom);
    bus.req_addr   = 12'($urandom);
    bus.req_wdata  = $urandom;
  endtask

  initial begin
    #300000;
    mismatched++;
    $display("FAIL watchdog: got no completion by %0t expected finish", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_type   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    reset          = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    reset = 1'b1;

    // Signed then unsigned byte load from the upper lane of word 1.
    begin_req();
    exp_mem(1'b0, 11'h001, 16'h0, 1);
    fire(1'b0, TYPE_BYTE, 1'b1, 12'h003, 32'h0, 1'b1, 32'hFFFF_FF80, 1'b0, 3);
    begin_req();
    exp_mem(1'b0, 11'h001, 16'h0, 1);
    fire(1'b0, TYPE_BYTE, 1'b0, 12'h003, 32'h0, 1'b1, 32'h0000_0080, 1'b0, 3);

    // Aligned halfword store rewrites word 1 for the misaligned word load.
    begin_req();
    exp_mem(1'b1, 11'h001, 16'h4433, 1);
    fire(1'b1, TYPE_HALF, 1'b0, 12'h002, 32'hFFFF_4433, 1'b1, 32'h0, 1'b0, 2);

    begin_req();
    exp_mem(1'b0, 11'h000, 16'h0, 1);
    exp_mem(1'b0, 11'h001, 16'h0, 3);
    exp_mem(1'b0, 11'h002, 16'h0, 5);
    fire(1'b0, TYPE_WORD, 1'b1, 12'h001, 32'h0, 1'b1, 32'h5544_3322, 1'b0, 7);

    begin_req();
    exp_mem(1'b1, 11'h002, 16'h1234, 1);
    fire(1'b1, TYPE_HALF, 1'b0, 12'h004, 32'h0000_1234, 1'b1, 32'h0, 1'b0, 2);

    // Byte store: read-modify-write of word 2.
    begin_req();
    exp_mem(1'b0, 11'h002, 16'h0, 1);
    exp_mem(1'b1, 11'h002, 16'h12AB, 3);
    fire(1'b1, TYPE_BYTE, 1'b0, 12'h004, 32'h0000_00AB, 1'b1, 32'h0, 1'b0, 4);

    begin_req();
    exp_mem(1'b1, 11'h004, 16'hBEEF, 1);
    exp_mem(1'b1, 11'h005, 16'hDEAD, 2);
    fire(1'b1, TYPE_WORD, 1'b0, 12'h008, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 3);

    begin_req();
    exp_mem(1'b0, 11'h004, 16'h0, 1);
    exp_mem(1'b0, 11'h005, 16'h0, 3);
    fire(1'b0, TYPE_WORD, 1'b0, 12'h008, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 5);

    // Signed halfword spanning words 2 and 3: bytes 0x12, 0xF8.
    begin_req();
    exp_mem(1'b0, 11'h002, 16'h0, 1);
    exp_mem(1'b0, 11'h003, 16'h0, 3);
    fire(1'b0, TYPE_HALF, 1'b1, 12'h005, 32'h0, 1'b1, 32'hFFFF_F812, 1'b0, 5);

    // Misaligned halfword store: two partial beats, each read then written.
    begin_req();
    exp_mem(1'b0, 11'h005, 16'h0, 1);
    exp_mem(1'b1, 11'h005, 16'hFEAD, 3);
    exp_mem(1'b0, 11'h006, 16'h0, 4);
    exp_mem(1'b1, 11'h006, 16'h99CA, 6);
    fire(1'b1, TYPE_HALF, 1'b0, 12'h00B, 32'h0000_CAFE, 1'b1, 32'h0, 1'b0, 7);

    // Illegal type: error response at T+1, no memory traffic.
    begin_req();
    fire(1'b1, TYPE_ILLEGAL, 1'b0, 12'h010, 32'h1234_5678, 1'b1, 32'h0, 1'b1, 1);
    check("illegal_ready_in_resp", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("illegal_ready_after", 32'(bus.req_ready), 32'd1);
    check("illegal_cycle", cyc, t_acc + 2);

    // Wrapping halfword load aborted by reset in the second RD_WAIT.
    begin_req();
    exp_mem(1'b0, 11'h7FF, 16'h0, 1);
    exp_mem(1'b0, 11'h000, 16'h0, 3);
    fire(1'b0, TYPE_HALF, 1'b0, 12'hFFF, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_mem_en", 32'(bus.mem_en), 32'd0);
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
